// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the read/write index masking rule for registers_bank_mp.
package regfile_pkg;

    typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

    localparam int RF_XLEN_DEF     = 32;
    localparam int RF_NREGS_DEF    = 32;
    localparam int RF_NREAD_DEF    = 2;
    localparam int RF_ZERO_REG_DEF = 1;

    // An index is masked when it addresses no storage or the hardwired zero register.
    function automatic logic rf_masked(input int idx, input int nregs, input int zero_reg);
        return (idx >= nregs) || ((zero_reg != 0) && (idx == 0));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue, cleared by writeback.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int NREAD = 2
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_clr_all,
    input  logic                              i_set_en,
    input  logic [$clog2(NREGS)-1:0]          i_set_sel,
    input  logic                              i_clr_en,
    input  logic [$clog2(NREGS)-1:0]          i_clr_sel,
    input  logic [NREAD*$clog2(NREGS)-1:0]    i_rd_sel,
    output logic [NREAD-1:0]                  o_busy
);

    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // A set and a clear on the same register resolve to set.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int k = 0; k < NREGS; k++) begin
            if (i_set_en && (i_set_sel == k[AW-1:0]))
                w_busy_nxt[k] = 1'b1;
            else if (i_clr_en && (i_clr_sel == k[AW-1:0]))
                w_busy_nxt[k] = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr_all)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    always_comb begin
        o_busy = '0;
        for (int i = 0; i < NREAD; i++)
            o_busy[i] = r_busy[i_rd_sel[i*AW +: AW]];
    end

endmodule

// File: rtl/registers_bank_mp.sv
// Multi-port register bank with pending-write scoreboard and sequential clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module registers_bank_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_DEF,
    parameter int NREGS    = RF_NREGS_DEF,
    parameter int NREAD    = RF_NREAD_DEF,
    parameter int ZERO_REG = RF_ZERO_REG_DEF
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clear_req,
    output logic                              ready,
    input  logic                              we,
    input  logic [$clog2(NREGS)-1:0]          sel_in,
    input  logic [XLEN-1:0]                   data_in,
    input  logic [NREAD*$clog2(NREGS)-1:0]    sel_out,
    output logic [NREAD*XLEN-1:0]             data_out,
    input  logic                              busy_set,
    input  logic [$clog2(NREGS)-1:0]          busy_sel,
    output logic [NREAD-1:0]                  busy_out
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_t       r_state;
    rf_state_t       w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic            w_clr_all;

    logic [XLEN-1:0] r_regs [NREGS];

    logic            w_run;
    logic            w_wr_ok;
    logic            w_set_ok;
    logic            w_st_we;
    logic [AW-1:0]   w_st_idx;
    logic [XLEN-1:0] w_st_data;
    logic [AW-1:0]   w_rd_sel [NREAD];
    logic [NREAD-1:0] w_sb_busy;

    assign w_run    = (r_state == RF_RUN);
    assign ready    = w_run;
    assign w_wr_ok  = !reset && w_run && we && !clear_req
                      && !rf_masked(int'(sel_in), NREGS, ZERO_REG);
    assign w_set_ok = !reset && w_run && busy_set && !clear_req
                      && !rf_masked(int'(busy_sel), NREGS, ZERO_REG);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RF_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_all   = 1'b0;
        case (r_state)
            RF_CLEAR: begin
                if (clear_req) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LAST_IDX) begin
                    w_state_nxt = RF_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RF_RUN: begin
                if (clear_req) begin
                    w_state_nxt = RF_CLEAR;
                    w_cnt_nxt   = '0;
                    w_clr_all   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = RF_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Single storage write port shared by the clear engine and writeback.
    always_comb begin
        w_st_we   = w_wr_ok;
        w_st_idx  = sel_in;
        w_st_data = data_in;
        if (!reset && (r_state == RF_CLEAR)) begin
            w_st_we   = 1'b1;
            w_st_idx  = r_cnt;
            w_st_data = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (w_st_we)
            r_regs[w_st_idx] <= w_st_data;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) u_scoreboard (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_clr_all (w_clr_all),
        .i_set_en  (w_set_ok),
        .i_set_sel (busy_sel),
        .i_clr_en  (w_wr_ok),
        .i_clr_sel (sel_in),
        .i_rd_sel  (sel_out),
        .o_busy    (w_sb_busy)
    );

    always_comb begin
        for (int i = 0; i < NREAD; i++)
            w_rd_sel[i] = sel_out[i*AW +: AW];
    end

    // Outputs are forced to zero while storage is being cleared.
    always_comb begin
        data_out = '0;
        busy_out = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (w_run && !rf_masked(int'(w_rd_sel[i]), NREGS, ZERO_REG)) begin
                data_out[i*XLEN +: XLEN] = r_regs[w_rd_sel[i]];
                busy_out[i]              = w_sb_busy[i];
`ifdef REGFILE_BYPASS_EN
                if (w_wr_ok && (sel_in == w_rd_sel[i])) begin
                    data_out[i*XLEN +: XLEN] = data_in;
                    busy_out[i]              = w_set_ok && (busy_sel == sel_in);
                end
`endif
            end
        end
    end

endmodule
